// File: rtl/pc_fetch_seq.sv
// Program-counter and instruction-fetch sequencer: drives imem, publishes PC+1, takes branch redirects.
// Optional FETCH_CNT_EN adds a saturating count of valid-fetch cycles on fetch_cnt.
module pc_fetch_seq #(
    parameter int unsigned       ADDR_W   = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              stall,
    input  logic              halt,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              imem_gnt,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] ins_inc_addr,
    output logic              ins_valid,
    output logic              flush
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]       fetch_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        REDIRECT = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_d;
    logic              flush_d;

    // The request comes straight from state, so an async reset drops it without a clock.
    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = pc_q;
    assign ins_inc_addr = pc_q + ADDR_W'(1);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = 1'b0;
        flush_d = 1'b0;

        if (halt) begin
            state_d = HALTED;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (run) state_d = FETCH;
                end
                FETCH, REDIRECT: begin
                    if (br_taken) begin
                        pc_d    = br_target;
                        flush_d = 1'b1;
                        state_d = REDIRECT;
                    end else if (!run) begin
                        state_d = IDLE;
                    end else if (state_q == REDIRECT) begin
                        state_d = FETCH;
                    end else if (!stall && imem_gnt) begin
                        pc_d    = ins_inc_addr;
                        valid_d = 1'b1;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            ins_valid <= 1'b0;
            flush     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ins_valid <= valid_d;
            flush     <= flush_d;
        end
    end

`ifdef FETCH_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= 16'h0000;
        end else if (ins_valid && (fetch_cnt != 16'hFFFF)) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed self-checking bench for pc_fetch_seq (ADDR_W=10, RESET_PC=0).
// Define FETCH_CNT_EN for both files to also exercise the fetch counter.
module tb_pc_fetch_seq;

    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              stall;
    logic              halt;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              imem_gnt;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic [ADDR_W-1:0] ins_inc_addr;
    logic              ins_valid;
    logic              flush;
`ifdef FETCH_CNT_EN
    logic [15:0]       fetch_cnt;
`endif

    int errors = 0;
    int checks = 0;

    pc_fetch_seq #(.ADDR_W(ADDR_W), .RESET_PC(10'h000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .stall        (stall),
        .halt         (halt),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .imem_gnt     (imem_gnt),
        .imem_addr    (imem_addr),
        .imem_req     (imem_req),
        .ins_inc_addr (ins_inc_addr),
        .ins_valid    (ins_valid),
        .flush        (flush)
`ifdef FETCH_CNT_EN
        ,
        .fetch_cnt    (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [ADDR_W-1:0] addr,
                              input logic req, input logic valid, input logic fl);
        checks++;
        if (imem_addr !== addr) begin
            errors++;
            $display("FAIL %s imem_addr: got %h expected %h", name, imem_addr, addr);
        end
        checks++;
        if (imem_req !== req) begin
            errors++;
            $display("FAIL %s imem_req: got %b expected %b", name, imem_req, req);
        end
        checks++;
        if (ins_valid !== valid) begin
            errors++;
            $display("FAIL %s ins_valid: got %b expected %b", name, ins_valid, valid);
        end
        checks++;
        if (flush !== fl) begin
            errors++;
            $display("FAIL %s flush: got %b expected %b", name, flush, fl);
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        run       = 1'b0;
        stall     = 1'b0;
        halt      = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        imem_gnt  = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        expect_out("reset", 10'h000, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ins_inc_addr !== 10'h001) begin
            errors++;
            $display("FAIL reset ins_inc_addr: got %h expected %h", ins_inc_addr, 10'h001);
        end
    endtask

    task automatic test_sequential();
        logic [ADDR_W-1:0] exp_addr;
        run      = 1'b1;
        imem_gnt = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            exp_addr = ADDR_W'(i);
            expect_out($sformatf("seq[%0d]", i), exp_addr, 1'b1, (i >= 1), 1'b0);
            checks++;
            if (ins_inc_addr !== exp_addr + 10'd1) begin
                errors++;
                $display("FAIL seq[%0d] ins_inc_addr: got %h expected %h", i, ins_inc_addr,
                         exp_addr + 10'd1);
            end
            step();
        end
        run = 1'b0;
        step();
        expect_out("seq_stop", 10'h004, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        run = 1'b1;
        step();
        br_taken  = 1'b1;
        br_target = 10'h3FF;
        step();
        br_taken = 1'b0;
        expect_out("wrap_redirect", 10'h3FF, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("wrap_at_3ff", 10'h3FF, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ins_inc_addr !== 10'h000) begin
            errors++;
            $display("FAIL wrap ins_inc_addr: got %h expected %h", ins_inc_addr, 10'h000);
        end
        step();
        expect_out("wrap_after", 10'h000, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_branch();
        repeat (5) step();
        expect_out("br_at_5", 10'h005, 1'b1, 1'b1, 1'b0);
        br_taken  = 1'b1;
        br_target = 10'h120;
        step();
        br_taken = 1'b0;
        expect_out("br_bubble", 10'h120, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("br_target", 10'h120, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_redirect_restart();
        br_taken  = 1'b1;
        br_target = 10'h200;
        step();
        br_target = 10'h2AA;
        step();
        br_taken = 1'b0;
        expect_out("restart_bubble", 10'h2AA, 1'b0, 1'b0, 1'b1);
        step();
        expect_out("restart_fetch", 10'h2AA, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        br_taken  = 1'b1;
        br_target = 10'h007;
        step();
        br_taken = 1'b0;
        step();
        expect_out("stall_at_7", 10'h007, 1'b1, 1'b0, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("stall[%0d]", i), 10'h007, 1'b1, 1'b0, 1'b0);
        end
        stall = 1'b0;
        step();
        expect_out("stall_release", 10'h008, 1'b1, 1'b1, 1'b0);
        imem_gnt = 1'b0;
        step();
        expect_out("no_gnt", 10'h008, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        imem_gnt  = 1'b1;
        halt      = 1'b1;
        br_taken  = 1'b1;
        br_target = 10'h055;
        step();
        halt = 1'b0;
        expect_out("halt_enter", 10'h008, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("halted[%0d]", i), 10'h008, 1'b0, 1'b0, 1'b0);
        end
        br_taken = 1'b0;
        rst_n    = 1'b0;
        #1;
        expect_out("halt_reset", 10'h000, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        run   = 1'b0;
        step();
        expect_out("halt_after_reset", 10'h000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        run      = 1'b1;
        imem_gnt = 1'b1;
        step();
        step();
        expect_out("mid_req", 10'h001, 1'b1, 1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("async_drop", 10'h000, 1'b0, 1'b0, 1'b0);
        run   = 1'b0;
        rst_n = 1'b1;
        step();
        expect_out("async_after", 10'h000, 1'b0, 1'b0, 1'b0);
        imem_gnt = 1'b0;
    endtask

`ifdef FETCH_CNT_EN
    task automatic test_fetch_cnt();
        apply_reset();
        checks++;
        if (fetch_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL cnt_reset: got %h expected %h", fetch_cnt, 16'h0000);
        end
        run      = 1'b1;
        imem_gnt = 1'b1;
        step();
        repeat (5) step();
        br_taken  = 1'b1;
        br_target = 10'h040;
        step();
        br_taken = 1'b0;
        step();
        run = 1'b0;
        step();
        checks++;
        if (fetch_cnt !== 16'd5) begin
            errors++;
            $display("FAIL cnt_five: got %0d expected %0d", fetch_cnt, 5);
        end
        run = 1'b1;
        step();
        repeat (65540) step();
        checks++;
        if (fetch_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_saturate: got %h expected %h", fetch_cnt, 16'hFFFF);
        end
        repeat (3) step();
        checks++;
        if (fetch_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL cnt_hold: got %h expected %h", fetch_cnt, 16'hFFFF);
        end
        run = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_branch();
        test_redirect_restart();
        test_stall();
        test_halt();
        test_async_reset();
`ifdef FETCH_CNT_EN
        test_fetch_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
